blit_addr_stepper: RTL and testbench

Parametrised, pipelined successor to the blitter X/Y address adder. Holds integer+fraction X/Y pointers for `CHANNELS` independent address generators (A1, A2, …). Per accepted step command, advances one channel by a phrase, a pixel or a programmed fractional increment, with optional subtract and window wrap. Returns the new pointer through a valid/ready output port. Sits between the blitter state machine and the address-to-DRAM translator.

---
 rtl/blit_pkg.sv | 33 +++
 rtl/blit_step_alu.sv | 41 ++++
 rtl/blit_addr_stepper.sv | 228 ++++++++++++++++++++++
 tb/tb_blit_addr_stepper.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared types and helpers for the blitter address stepper and its per-axis ALU.
package blit_pkg;

    typedef enum logic [1:0] {
        XM_PHRASE = 2'd0,
        XM_PIXEL  = 2'd1,
        XM_NONE   = 2'd2,
        XM_INC    = 2'd3
    } xmode_e;

    localparam logic [2:0] LD_XY       = 3'd0;
    localparam logic [2:0] LD_FRAC     = 3'd1;
    localparam logic [2:0] LD_INC      = 3'd2;
    localparam logic [2:0] LD_INC_FRAC = 3'd3;
    localparam logic [2:0] LD_WIN      = 3'd4;

    localparam logic [2:0] PIX_1BPP  = 3'd0;
    localparam logic [2:0] PIX_2BPP  = 3'd1;
    localparam logic [2:0] PIX_4BPP  = 3'd2;
    localparam logic [2:0] PIX_8BPP  = 3'd3;
    localparam logic [2:0] PIX_16BPP = 3'd4;
    localparam logic [2:0] PIX_32BPP = 3'd5;
    localparam logic [2:0] PIX_64BPP = 3'd6;

    // Pixels per 64-bit phrase; the unused code 7 degrades to a single pixel.
    function automatic logic [6:0] phrase_pix(input logic [2:0] pixsize);
        if (pixsize > PIX_64BPP)
            phrase_pix = 7'd1;
        else
            phrase_pix = 7'd64 >> pixsize;
    endfunction

endpackage

// File: rtl/blit_step_alu.sv
// One axis of the stepper: {int,frac} add/sub, pixel step or phrase-aligned step.
module blit_step_alu
    import blit_pkg::*;
#(
    parameter int INT_W = 16,
    parameter int FW    = 16
) (
    input  logic [INT_W-1:0] pos_int,
    input  logic [FW-1:0]    pos_frac,
    input  logic [INT_W-1:0] inc_int,
    input  logic [FW-1:0]    inc_frac,
    input  xmode_e           mode,
    input  logic             sub,
    input  logic [2:0]       pixsize,
    output logic [INT_W-1:0] res_int,
    output logic [FW-1:0]    res_frac
);

    logic [INT_W-1:0]    ppp;
    logic [INT_W-1:0]    aligned;
    logic [INT_W+FW-1:0] acc;
    logic [INT_W+FW-1:0] opnd;
    logic [INT_W+FW-1:0] sum;

    always_comb begin
        ppp      = INT_W'(phrase_pix(pixsize));
        aligned  = pos_int & ~(ppp - INT_W'(1));
        acc      = {pos_int, pos_frac};
        opnd     = {inc_int, inc_frac};
        sum      = sub ? acc - opnd : acc + opnd;
        res_int  = pos_int;
        res_frac = pos_frac;
        case (mode)
            XM_PHRASE: res_int = sub ? aligned - ppp : aligned + ppp;
            XM_PIXEL:  res_int = sub ? pos_int - INT_W'(1) : pos_int + INT_W'(1);
            XM_INC:    {res_int, res_frac} = sum;
            default:   ;
        endcase
    end

endmodule

// File: rtl/blit_addr_stepper.sv
// Two-stage blitter X/Y pointer stepper: per-channel register file, S1 step math
// with S2 forwarding, S2 window wrap + writeback + valid/ready result port.
module blit_addr_stepper
    import blit_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int INT_W    = 16,
    parameter int FRAC_W   = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             ld_valid,
    input  logic [CH_W-1:0]  ld_ch,
    input  logic [2:0]       ld_sel,
    input  logic [INT_W-1:0] ld_x,
    input  logic [INT_W-1:0] ld_y,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [CH_W-1:0]  st_ch,
    input  logic [1:0]       st_xmode,
    input  logic             st_ystep,
    input  logic             st_subx,
    input  logic             st_suby,
    input  logic [2:0]       pixsize,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [INT_W-1:0] out_x,
    output logic [INT_W-1:0] out_y
);

    localparam int FW = (FRAC_W > 0) ? FRAC_W : 1;

    logic [INT_W-1:0] x_q     [CHANNELS];
    logic [INT_W-1:0] y_q     [CHANNELS];
    logic [FW-1:0]    fx_q    [CHANNELS];
    logic [FW-1:0]    fy_q    [CHANNELS];
    logic [INT_W-1:0] ix_q    [CHANNELS];
    logic [INT_W-1:0] iy_q    [CHANNELS];
    logic [FW-1:0]    ifx_q   [CHANNELS];
    logic [FW-1:0]    ify_q   [CHANNELS];
    logic [INT_W-1:0] win_w_q [CHANNELS];
    logic             wrap_en_q [CHANNELS];

    logic             s1_valid;
    logic [CH_W-1:0]  s1_ch;
    xmode_e           s1_xmode;
    logic             s1_ystep;
    logic             s1_subx;
    logic             s1_suby;
    logic [2:0]       s1_pixsize;

    logic             s2_valid;
    logic             s2_wb_pending;
    logic [CH_W-1:0]  s2_ch;
    logic [INT_W-1:0] s2_x;
    logic [INT_W-1:0] s2_y;
    logic [FW-1:0]    s2_fx;
    logic [FW-1:0]    s2_fy;
    logic [INT_W-1:0] s2_win_w;
    logic             s2_wrap_en;

    logic             advance;
    logic             st_fire;
    logic             fwd;
    logic [INT_W-1:0] wrap_x;
    logic [INT_W-1:0] cur_x;
    logic [INT_W-1:0] cur_y;
    logic [FW-1:0]    cur_fx;
    logic [FW-1:0]    cur_fy;
    logic [INT_W-1:0] nx;
    logic [INT_W-1:0] ny;
    logic [FW-1:0]    nfx;
    logic [FW-1:0]    nfy;
    xmode_e           ymode;

    assign advance  = !s2_valid || out_ready;
    assign st_ready = !ld_valid && advance;
    assign st_fire  = st_valid && st_ready;

    // Only one correction: a single step is smaller than the window.
    always_comb begin
        wrap_x = s2_x;
        if (s2_wrap_en) begin
            if (s2_x[INT_W-1])
                wrap_x = s2_x + s2_win_w;
            else if (s2_x >= s2_win_w)
                wrap_x = s2_x - s2_win_w;
        end
    end

    // S2 holds the newest value of its channel whether or not it has written back yet.
    always_comb begin
        fwd    = s2_valid && (s2_ch == s1_ch);
        cur_x  = fwd ? wrap_x : x_q[s1_ch];
        cur_y  = fwd ? s2_y   : y_q[s1_ch];
        cur_fx = fwd ? s2_fx  : fx_q[s1_ch];
        cur_fy = fwd ? s2_fy  : fy_q[s1_ch];
        ymode  = s1_ystep ? XM_INC : XM_NONE;
    end

    blit_step_alu #(.INT_W(INT_W), .FW(FW)) u_alu_x (
        .pos_int  (cur_x),
        .pos_frac (cur_fx),
        .inc_int  (ix_q[s1_ch]),
        .inc_frac (ifx_q[s1_ch]),
        .mode     (s1_xmode),
        .sub      (s1_subx),
        .pixsize  (s1_pixsize),
        .res_int  (nx),
        .res_frac (nfx)
    );

    blit_step_alu #(.INT_W(INT_W), .FW(FW)) u_alu_y (
        .pos_int  (cur_y),
        .pos_frac (cur_fy),
        .inc_int  (iy_q[s1_ch]),
        .inc_frac (ify_q[s1_ch]),
        .mode     (ymode),
        .sub      (s1_suby),
        .pixsize  (s1_pixsize),
        .res_int  (ny),
        .res_frac (nfy)
    );

    // Writeback is placed after loads so an in-flight result overwrites a same-edge load.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                x_q[c]       <= '0;
                y_q[c]       <= '0;
                fx_q[c]      <= '0;
                fy_q[c]      <= '0;
                ix_q[c]      <= '0;
                iy_q[c]      <= '0;
                ifx_q[c]     <= '0;
                ify_q[c]     <= '0;
                win_w_q[c]   <= '0;
                wrap_en_q[c] <= 1'b0;
            end
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (ld_valid && ld_ch == CH_W'(c)) begin
                    case (ld_sel)
                        LD_XY: begin
                            x_q[c] <= ld_x;
                            y_q[c] <= ld_y;
                        end
                        LD_FRAC: begin
                            fx_q[c] <= (FRAC_W > 0) ? FW'(ld_x) : '0;
                            fy_q[c] <= (FRAC_W > 0) ? FW'(ld_y) : '0;
                        end
                        LD_INC: begin
                            ix_q[c] <= ld_x;
                            iy_q[c] <= ld_y;
                        end
                        LD_INC_FRAC: begin
                            ifx_q[c] <= (FRAC_W > 0) ? FW'(ld_x) : '0;
                            ify_q[c] <= (FRAC_W > 0) ? FW'(ld_y) : '0;
                        end
                        LD_WIN: begin
                            win_w_q[c]   <= ld_x;
                            wrap_en_q[c] <= ld_y[0];
                        end
                        default: ;
                    endcase
                end
                if (s2_wb_pending && s2_ch == CH_W'(c)) begin
                    x_q[c]  <= wrap_x;
                    y_q[c]  <= s2_y;
                    fx_q[c] <= s2_fx;
                    fy_q[c] <= s2_fy;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_ch         <= '0;
            s1_xmode      <= XM_NONE;
            s1_ystep      <= 1'b0;
            s1_subx       <= 1'b0;
            s1_suby       <= 1'b0;
            s1_pixsize    <= '0;
            s2_valid      <= 1'b0;
            s2_wb_pending <= 1'b0;
            s2_ch         <= '0;
            s2_x          <= '0;
            s2_y          <= '0;
            s2_fx         <= '0;
            s2_fy         <= '0;
            s2_win_w      <= '0;
            s2_wrap_en    <= 1'b0;
        end else begin
            s2_wb_pending <= advance && s1_valid;
            if (advance) begin
                s1_valid <= st_fire;
                if (st_fire) begin
                    s1_ch      <= st_ch;
                    s1_xmode   <= xmode_e'(st_xmode);
                    s1_ystep   <= st_ystep;
                    s1_subx    <= st_subx;
                    s1_suby    <= st_suby;
                    s1_pixsize <= pixsize;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_ch      <= s1_ch;
                    s2_x       <= nx;
                    s2_y       <= ny;
                    s2_fx      <= nfx;
                    s2_fy      <= nfy;
                    s2_win_w   <= win_w_q[s1_ch];
                    s2_wrap_en <= wrap_en_q[s1_ch];
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_ch    = s2_ch;
    assign out_x     = wrap_x;
    assign out_y     = s2_y;

endmodule

// File: tb/tb_blit_addr_stepper.sv
// Scoreboard bench for blit_addr_stepper: expectations queued on step accept, checked on output handshake.
module tb_blit_addr_stepper;

    localparam logic [1:0] PHRASE = 2'd0;
    localparam logic [1:0] PIXEL  = 2'd1;
    localparam logic [1:0] NONE   = 2'd2;
    localparam logic [1:0] INC    = 2'd3;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [0:0]  ld_ch = '0;
    logic [2:0]  ld_sel = '0;
    logic [15:0] ld_x = '0;
    logic [15:0] ld_y = '0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [0:0]  st_ch = '0;
    logic [1:0]  st_xmode = '0;
    logic        st_ystep = 1'b0;
    logic        st_subx = 1'b0;
    logic        st_suby = 1'b0;
    logic [2:0]  pixsize = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [0:0]  out_ch;
    logic [15:0] out_x;
    logic [15:0] out_y;

    typedef struct packed {
        logic [0:0]  ch;
        logic [15:0] x;
        logic [15:0] y;
    } sb_t;

    sb_t   exp_q[$];
    string name_q[$];
    int    check_cnt = 0;
    int    pass_cnt = 0;

    blit_addr_stepper #(.CHANNELS(2), .INT_W(16), .FRAC_W(16)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_ch     (ld_ch),
        .ld_sel    (ld_sel),
        .ld_x      (ld_x),
        .ld_y      (ld_y),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_ch     (st_ch),
        .st_xmode  (st_xmode),
        .st_ystep  (st_ystep),
        .st_subx   (st_subx),
        .st_suby   (st_suby),
        .pixsize   (pixsize),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_x     (out_x),
        .out_y     (out_y)
    );

    always #5 sys_clk = ~sys_clk;

    // Scoreboard consumer: one comparison per completed output handshake.
    always @(negedge sys_clk) begin
        sb_t   e;
        string nm;
        if (!reset && out_valid && out_ready) begin
            check_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got ch=%0d x=%h y=%h, required no output", out_ch, out_x, out_y);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (out_ch !== e.ch || out_x !== e.x || out_y !== e.y)
                    $display("FAIL %s: got ch=%0d x=%h y=%h, required ch=%0d x=%h y=%h",
                             nm, out_ch, out_x, out_y, e.ch, e.x, e.y);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic load(input logic [0:0] ch, input logic [2:0] sel, input logic [15:0] x, input logic [15:0] y);
        ld_valid = 1'b1;
        ld_ch    = ch;
        ld_sel   = sel;
        ld_x     = x;
        ld_y     = y;
        @(posedge sys_clk);
        #1;
        ld_valid = 1'b0;
    endtask

    task automatic step(input logic [0:0] ch, input logic [1:0] xm, input logic ys, input logic sx,
                        input logic sy, input logic push, input logic [15:0] ex, input logic [15:0] ey,
                        input string nm);
        logic ok;
        logic rdy;
        sb_t  e;
        st_valid = 1'b1;
        st_ch    = ch;
        st_xmode = xm;
        st_ystep = ys;
        st_subx  = sx;
        st_suby  = sy;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge sys_clk);
            rdy = st_ready;
            @(posedge sys_clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        st_valid = 1'b0;
        if (!ok) begin
            check_cnt++;
            $display("FAIL %s_accept: st_ready stayed low, required accept within 10 cycles", nm);
        end else if (push) begin
            e.ch = ch;
            e.x  = ex;
            e.y  = ey;
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge sys_clk);
        #1;
        check_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_drain: %0d results outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid); else pass_cnt++;
        check_cnt++;
        if (out_x !== 16'h0) $display("FAIL rst_out_x: got %h, required 0000", out_x); else pass_cnt++;
        check_cnt++;
        if (out_y !== 16'h0) $display("FAIL rst_out_y: got %h, required 0000", out_y); else pass_cnt++;
        check_cnt++;
        if (out_ch !== 1'b0) $display("FAIL rst_out_ch: got %0d, required 0", out_ch); else pass_cnt++;
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        @(negedge sys_clk);
        check_cnt++;
        if (st_ready !== 1'b1) $display("FAIL rst_st_ready: got %b, required 1", st_ready); else pass_cnt++;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_phrase();
        load(1'b0, 3'd0, 16'h0010, 16'h0000);
        pixsize = 3'd4;
        step(1'b0, PHRASE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0014, 16'h0000, "phrase16_1");
        @(negedge sys_clk);
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL latency_s1: got out_valid=%b, required 0", out_valid); else pass_cnt++;
        @(negedge sys_clk);
        check_cnt++;
        if (out_valid !== 1'b1) $display("FAIL latency_s2: got out_valid=%b, required 1", out_valid); else pass_cnt++;
        @(posedge sys_clk);
        #1;
        step(1'b0, PHRASE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0018, 16'h0000, "phrase16_2");
        pixsize = 3'd0;
        step(1'b0, PHRASE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, "phrase1_align");
        pixsize = 3'd2;
        step(1'b0, PHRASE, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0000, "phrase4_sub");
        wait_drain("phrase");
    endtask

    task automatic test_increment();
        load(1'b1, 3'd0, 16'h0005, 16'h0000);
        load(1'b1, 3'd3, 16'h8000, 16'h0000);
        step(1'b1, INC, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, "inc_half_1");
        step(1'b1, INC, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0006, 16'h0000, "inc_half_carry");
        wait_drain("increment");
    endtask

    task automatic test_wrap();
        load(1'b0, 3'd0, 16'd98, 16'h0000);
        load(1'b0, 3'd4, 16'd100, 16'h0001);
        step(1'b0, PIXEL, 1'b0, 1'b0, 1'b0, 1'b1, 16'd99, 16'h0000, "wrap_add_99");
        step(1'b0, PIXEL, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0,  16'h0000, "wrap_add_0");
        step(1'b0, PIXEL, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1,  16'h0000, "wrap_add_1");
        step(1'b0, PIXEL, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0,  16'h0000, "wrap_sub_0");
        step(1'b0, PIXEL, 1'b0, 1'b1, 1'b0, 1'b1, 16'd99, 16'h0000, "wrap_sub_99");
        wait_drain("wrap");
    endtask

    task automatic test_subtract_y();
        load(1'b1, 3'd0, 16'h0020, 16'h0000);
        load(1'b1, 3'd2, 16'h0000, 16'h0001);
        step(1'b1, NONE, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 16'hFFFF, "suby_borrow");
        step(1'b1, NONE, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, "addy_rollover");
        wait_drain("subtract_y");
    endtask

    task automatic test_backpressure();
        int   acc;
        logic rdy;
        logic stable;
        sb_t  e;
        load(1'b0, 3'd0, 16'd10, 16'h0000);
        load(1'b0, 3'd4, 16'd0, 16'h0000);
        out_ready = 1'b0;
        st_valid  = 1'b1;
        st_ch     = 1'b0;
        st_xmode  = PIXEL;
        st_ystep  = 1'b0;
        st_subx   = 1'b0;
        st_suby   = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            rdy = st_ready;
            @(posedge sys_clk);
            #1;
            if (rdy) begin
                acc++;
                e.ch = 1'b0;
                e.x  = 16'd10 + 16'(acc);
                e.y  = 16'h0000;
                exp_q.push_back(e);
                name_q.push_back($sformatf("bp_result_%0d", acc));
            end
        end
        st_valid = 1'b0;
        check_cnt++;
        if (acc != 2) $display("FAIL bp_accepted: got %0d steps, required 2", acc); else pass_cnt++;
        stable = 1'b1;
        repeat (4) begin
            @(negedge sys_clk);
            if (out_valid !== 1'b1 || out_x !== 16'd11 || out_ch !== 1'b0) stable = 1'b0;
        end
        check_cnt++;
        if (!stable) $display("FAIL bp_hold: got valid=%b x=%h, required valid=1 x=000b held", out_valid, out_x);
        else pass_cnt++;
        @(posedge sys_clk);
        #1;
        out_ready = 1'b1;
        wait_drain("backpressure");
        step(1'b0, PIXEL, 1'b0, 1'b0, 1'b0, 1'b1, 16'd13, 16'h0000, "bp_after_release");
        wait_drain("bp_after");
    endtask

    task automatic test_reset_mid();
        logic quiet;
        load(1'b1, 3'd0, 16'h0040, 16'h0000);
        out_ready = 1'b0;
        step(1'b1, PIXEL, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, "mid_a");
        step(1'b1, PIXEL, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, "mid_b");
        #1;
        check_cnt++;
        if (out_valid !== 1'b1) $display("FAIL mid_full: got out_valid=%b, required 1", out_valid); else pass_cnt++;
        #1;
        reset = 1'b1;
        #1;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL mid_rst_async: got out_valid=%b, required 0", out_valid); else pass_cnt++;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        quiet = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        check_cnt++;
        if (!quiet) $display("FAIL mid_no_output: got out_valid=%b after reset, required 0", out_valid);
        else pass_cnt++;
        @(posedge sys_clk);
        #1;
        step(1'b1, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, "mid_regs_cleared");
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_phrase();
        test_increment();
        test_wrap();
        test_subtract_y();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog");
    end

endmodule
